gpio_chain_monitor: RTL and testbench
=====================================

// Module: gpio_chain_monitor
// PURPOSE
//  Sits at the tail of the GPIO configuration shift chain and consumes the serial_data_out of the last pad control block.
//  - Deserialises the returned stream into PAD_CTRL_BITS-wide per-pad words.
//  - Counts the words in each frame and computes a CRC-16 over the frame.
//  - Flags a complete, matching frame so housekeeping can confirm the chain was programmed intact before asserting serial_load.
// PARAMETERS
//  PAD_CTRL_BITS  13      config bits per pad, equals the pad control block shift width
//  NUM_PADS       19      pads in the chain, which is the number of words per frame
//  CRC_INIT       16'hFFFF  CRC-16-CCITT seed, loaded on reset and on frame_clr
// PORTS
//  serial_clock  in   1               chain clock; all state updates on its rising edge
//  resetn        in   1               asynchronous, active-low reset
//  serial_data_in in  1               chain tail data, launched by the upstream block on the falling edge
//  shift_en      in   1               bit on serial_data_in is valid at this rising edge
//  frame_clr     in   1               synchronous frame restart
//  expected_crc  in   16              CRC that housekeeping expects for the frame
//  word_out      out  PAD_CTRL_BITS   last completed word, first-received bit in the MSB
//  word_valid    out  1               one-cycle pulse when word_out updates
//  word_index    out  $clog2(NUM_PADS)  index of word_out in arrival order, 0 = first word
//  frame_done    out  1               level signal: NUM_PADS words received
//  crc_out       out  16              running CRC
//  crc_match     out  1               frame_done && crc_out==expected_crc
//  overrun       out  1               sticky: a bit arrived after frame_done
//  rd_addr       in   $clog2(NUM_PADS)  capture buffer read address
//  rd_data       out  PAD_CTRL_BITS   capture buffer read data
// BEHAVIOUR
//  Reset values: word_out=0, word_valid=0, word_index=0, frame_done=0, crc_out=CRC_INIT, crc_match=0, overrun=0, FSM=IDLE.
//  FSM states:
//   - IDLE: shift_en -> SHIFT; that first bit is accepted in the same cycle.
//   - SHIFT: counts bits and words; the NUM_PADS-th completed word -> DONE.
//   - DONE: a shift_en -> OVERRUN.
//   - OVERRUN: holds until frame_clr or reset.
//  Accepted bit (shift_en=1 in IDLE or SHIFT):
//   - shifts into the word register LSB;
//   - CRC update: fb=crc[15]^bit; crc={crc[14:0],1'b0}^(fb?16'h1021:0);
//   - bit counter increments, range 0..PAD_CTRL_BITS-1.
//  Word completion:
//   - Triggered when the bit counter wraps from PAD_CTRL_BITS-1 to 0.
//   - word_out and word_index are registered and word_valid=1 on the next cycle (latency 1 after the 13th bit).
//   - The word counter increments.
//  frame_done asserts in the same cycle as the final word_valid.
//  crc_match is registered and updates that same cycle; it is re-evaluated each cycle while frame_done=1, so it tracks expected_crc changes.
//  DONE or OVERRUN with shift_en=1: the bit is discarded, CRC and words are frozen, overrun=1 (sticky).
//  frame_clr (highest priority, including over a same-edge shift_en, whose bit is dropped):
//   - resets counters, CRC, frame_done, crc_match, overrun, word_valid; FSM -> IDLE;
//   - word_out and word_index retain their values.
//  shift_en=0 in SHIFT: all state is held. A partial word is never emitted.
//  resetn low mid-frame: all state is cleared asynchronously and the partial frame is lost.
//  word_index is 0..NUM_PADS-1 and does not wrap within a frame.
// CONFIGURATION
//  GPIO_MON_CAPTURE_EN defined:
//   - Instantiates a NUM_PADS x PAD_CTRL_BITS register array; entry word_index is written on each word completion.
//   - rd_data = array[rd_addr], combinational; rd_addr >= NUM_PADS returns 0.
//   - The array is cleared by resetn only, not by frame_clr.
//  GPIO_MON_CAPTURE_EN undefined: no array is built, rd_data is tied to 0, rd_addr is ignored.
// TESTING
//  1. Reset, then 13 bits of 13'h1803 shifted MSB-first with shift_en=1 -> one cycle later word_out=13'h1803, word_valid=1 for one cycle, word_index=0.
//  2. Full frame of 19 words of 13'h0403 -> frame_done=1 after the 247th bit, crc_out equals the bench model, crc_match=1 with expected_crc=model and 0 with model^1.
//  3. After frame_done, one more shift_en bit -> overrun=1, crc_out unchanged, no word_valid; then frame_clr -> overrun=0, frame_done=0, crc_out=16'hFFFF.
//  4. shift_en deasserted for 5 cycles mid-word (after bit 6) -> no word_valid; the word completes correctly after the remaining 7 bits.
//  5. frame_clr and shift_en on the same edge during bit 10 of word 3 -> bit dropped, FSM=IDLE, the next 13 bits produce word_index=0.
//  6. resetn pulsed low after word 8 -> all outputs at reset values immediately. With GPIO_MON_CAPTURE_EN: a full frame, then rd_addr=4 -> rd_data=word 4, rd_addr=25 -> rd_data=0.

Source files
------------

// File: rtl/gpio_chain_monitor.sv
// ============================================================================
// gpio_chain_monitor : GPIO shift-chain tail monitor (deserialiser, CRC-16, frame check)
// Optional capture buffer built when GPIO_MON_CAPTURE_EN is defined.  Rev 1.0
// ============================================================================
`default_nettype none

module gpio_chain_monitor #(
  parameter int          PAD_CTRL_BITS = 13,
  parameter int          NUM_PADS      = 19,
  parameter logic [15:0] CRC_INIT      = 16'hFFFF
) (
  input  logic                          serial_clock,
  input  logic                          resetn,
  input  logic                          serial_data_in,
  input  logic                          shift_en,
  input  logic                          frame_clr,
  input  logic [15:0]                   expected_crc,
  output logic [PAD_CTRL_BITS-1:0]      word_out,
  output logic                          word_valid,
  output logic [$clog2(NUM_PADS)-1:0]   word_index,
  output logic                          frame_done,
  output logic [15:0]                   crc_out,
  output logic                          crc_match,
  output logic                          overrun,
  input  logic [$clog2(NUM_PADS)-1:0]   rd_addr,
  output logic [PAD_CTRL_BITS-1:0]      rd_data
);

  localparam int BIT_W = $clog2(PAD_CTRL_BITS);
  localparam int IDX_W = $clog2(NUM_PADS);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SHIFT   = 2'd1;
  localparam logic [1:0] ST_DONE    = 2'd2;
  localparam logic [1:0] ST_OVERRUN = 2'd3;

  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(PAD_CTRL_BITS - 1);
  localparam logic [BIT_W-1:0] BIT_ONE   = BIT_W'(1);
  localparam logic [IDX_W-1:0] LAST_WORD = IDX_W'(NUM_PADS - 1);
  localparam logic [IDX_W-1:0] WORD_ONE  = IDX_W'(1);

  logic [1:0]               state_q, state_d;
  logic [BIT_W-1:0]         bit_cnt_q, bit_cnt_d;
  logic [IDX_W-1:0]         word_cnt_q, word_cnt_d;
  logic [PAD_CTRL_BITS-2:0] shreg_q, shreg_d;
  logic [PAD_CTRL_BITS-1:0] word_out_q, word_out_d;
  logic [IDX_W-1:0]         word_index_q, word_index_d;
  logic                     word_valid_q, word_valid_d;
  logic                     frame_done_q, frame_done_d;
  logic [15:0]              crc_q, crc_d;
  logic                     crc_match_q, crc_match_d;
  logic                     overrun_q, overrun_d;

  logic                     accept;
  logic                     word_done;
  logic                     last_word;
  logic                     crc_fb;
  logic [15:0]              crc_next;
  logic [PAD_CTRL_BITS-1:0] new_word;

  // frame_clr wins over a same-edge shift_en, so that bit is never accepted
  assign accept    = shift_en && !frame_clr && (state_q == ST_IDLE || state_q == ST_SHIFT);
  assign word_done = accept && (bit_cnt_q == LAST_BIT);
  assign last_word = (word_cnt_q == LAST_WORD);
  assign new_word  = {shreg_q, serial_data_in};
  assign crc_fb    = crc_q[15] ^ serial_data_in;
  assign crc_next  = {crc_q[14:0], 1'b0} ^ (crc_fb ? 16'h1021 : 16'h0000);

  always_ff @(posedge serial_clock or negedge resetn) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (frame_clr) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_SHIFT: if (accept) state_d = (word_done && last_word) ? ST_DONE : ST_SHIFT;
        ST_DONE:           if (shift_en) state_d = ST_OVERRUN;
        default:           state_d = state_q;
      endcase
    end
  end

  always_comb begin
    bit_cnt_d    = bit_cnt_q;
    word_cnt_d   = word_cnt_q;
    shreg_d      = shreg_q;
    word_out_d   = word_out_q;
    word_index_d = word_index_q;
    word_valid_d = 1'b0;
    frame_done_d = frame_done_q;
    crc_d        = crc_q;
    overrun_d    = overrun_q;
    if (frame_clr) begin
      bit_cnt_d    = '0;
      word_cnt_d   = '0;
      shreg_d      = '0;
      frame_done_d = 1'b0;
      crc_d        = CRC_INIT;
      overrun_d    = 1'b0;
    end else if (accept) begin
      shreg_d   = new_word[PAD_CTRL_BITS-2:0];
      crc_d     = crc_next;
      bit_cnt_d = word_done ? '0 : bit_cnt_q + BIT_ONE;
      if (word_done) begin
        word_out_d   = new_word;
        word_index_d = word_cnt_q;
        word_valid_d = 1'b1;
        // the word counter parks on the last index; frame_done marks completion
        word_cnt_d   = last_word ? word_cnt_q : word_cnt_q + WORD_ONE;
        if (last_word) frame_done_d = 1'b1;
      end
    end else if (shift_en) begin
      overrun_d = 1'b1;
    end
    crc_match_d = frame_done_d && (crc_d == expected_crc);
  end

  always_ff @(posedge serial_clock or negedge resetn) begin
    if (!resetn) begin
      bit_cnt_q    <= '0;
      word_cnt_q   <= '0;
      shreg_q      <= '0;
      word_out_q   <= '0;
      word_index_q <= '0;
      word_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
      crc_q        <= CRC_INIT;
      crc_match_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      bit_cnt_q    <= bit_cnt_d;
      word_cnt_q   <= word_cnt_d;
      shreg_q      <= shreg_d;
      word_out_q   <= word_out_d;
      word_index_q <= word_index_d;
      word_valid_q <= word_valid_d;
      frame_done_q <= frame_done_d;
      crc_q        <= crc_d;
      crc_match_q  <= crc_match_d;
      overrun_q    <= overrun_d;
    end
  end

  assign word_out   = word_out_q;
  assign word_valid = word_valid_q;
  assign word_index = word_index_q;
  assign frame_done = frame_done_q;
  assign crc_out    = crc_q;
  assign crc_match  = crc_match_q;
  assign overrun    = overrun_q;

`ifdef GPIO_MON_CAPTURE_EN
  // capture survives frame_clr so a frame can be read back after restarting
  logic [PAD_CTRL_BITS-1:0] cap_q [NUM_PADS];
  logic [PAD_CTRL_BITS-1:0] cap_d [NUM_PADS];

  always_comb begin
    cap_d = cap_q;
    if (word_done) cap_d[word_cnt_q] = new_word;
  end

  always_ff @(posedge serial_clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_PADS; i++) cap_q[i] <= '0;
    end else begin
      cap_q <= cap_d;
    end
  end

  assign rd_data = (int'(rd_addr) < NUM_PADS) ? cap_q[rd_addr] : '0;
`else
  logic unused_rd_addr;
  assign unused_rd_addr = ^rd_addr;
  assign rd_data        = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_gpio_chain_monitor.sv
// ============================================================================
// tb_gpio_chain_monitor : scoreboard bench for gpio_chain_monitor
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_gpio_chain_monitor;
  localparam int PB = 13;
  localparam int NP = 19;
  localparam int IW = $clog2(NP);

  logic          serial_clock = 1'b0;
  logic          resetn;
  logic          serial_data_in;
  logic          shift_en;
  logic          frame_clr;
  logic [15:0]   expected_crc;
  logic [PB-1:0] word_out;
  logic          word_valid;
  logic [IW-1:0] word_index;
  logic          frame_done;
  logic [15:0]   crc_out;
  logic          crc_match;
  logic          overrun;
  logic [IW-1:0] rd_addr;
  logic [PB-1:0] rd_data;

  gpio_chain_monitor #(.PAD_CTRL_BITS(PB), .NUM_PADS(NP), .CRC_INIT(16'hFFFF)) dut (
    .serial_clock  (serial_clock),
    .resetn        (resetn),
    .serial_data_in(serial_data_in),
    .shift_en      (shift_en),
    .frame_clr     (frame_clr),
    .expected_crc  (expected_crc),
    .word_out      (word_out),
    .word_valid    (word_valid),
    .word_index    (word_index),
    .frame_done    (frame_done),
    .crc_out       (crc_out),
    .crc_match     (crc_match),
    .overrun       (overrun),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data)
  );

  always #5 serial_clock = ~serial_clock;

  typedef struct packed {
    logic [PB-1:0] w;
    logic [IW-1:0] idx;
    logic          last;
  } exp_t;

  exp_t          sb_q[$];
  int            vectors = 0;
  int            miscompares = 0;
  logic [15:0]   crc_m;
  logic [15:0]   crc_saved;
  logic [PB-1:0] cap_w4;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic crc_step(input logic b);
    logic fb;
    fb    = crc_m[15] ^ b;
    crc_m = {crc_m[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endtask

  task automatic send_bit(input logic b);
    shift_en       = 1'b1;
    serial_data_in = b;
    @(posedge serial_clock);
    #2;
  endtask

  task automatic idle(input int n);
    shift_en = 1'b0;
    repeat (n) begin
      @(posedge serial_clock);
      #2;
    end
  endtask

  task automatic send_word(input logic [PB-1:0] w, input int idx, input logic last, input int stall_after);
    for (int i = PB - 1; i >= 0; i--) begin
      if (i == 0) sb_q.push_back('{w: w, idx: IW'(idx), last: last});
      crc_step(w[i]);
      send_bit(w[i]);
      if (stall_after > 0 && i == PB - stall_after) idle(5);
    end
  endtask

  task automatic clear_frame();
    shift_en  = 1'b0;
    frame_clr = 1'b1;
    @(posedge serial_clock);
    #2;
    frame_clr = 1'b0;
    crc_m     = 16'hFFFF;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_word_out"},   32'(word_out),   32'h0);
    check({tag, "_word_valid"}, 32'(word_valid), 32'h0);
    check({tag, "_word_index"}, 32'(word_index), 32'h0);
    check({tag, "_frame_done"}, 32'(frame_done), 32'h0);
    check({tag, "_crc_out"},    32'(crc_out),    32'hFFFF);
    check({tag, "_crc_match"},  32'(crc_match),  32'h0);
    check({tag, "_overrun"},    32'(overrun),    32'h0);
  endtask

  // scoreboard monitor: every word_valid pulse must match the oldest expectation
  always @(negedge serial_clock) begin
    exp_t e;
    if (resetn && word_valid) begin
      if (sb_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_word_valid: got word_out=%0h index=%0d, required no word_valid", word_out, word_index);
      end else begin
        e = sb_q.pop_front();
        check("sb_word_out",   32'(word_out),   32'(e.w));
        check("sb_word_index", 32'(word_index), 32'(e.idx));
        check("sb_frame_done", 32'(frame_done), 32'(e.last));
      end
    end
  end

  initial begin
    resetn         = 1'b0;
    serial_data_in = 1'b0;
    shift_en       = 1'b0;
    frame_clr      = 1'b0;
    expected_crc   = 16'h0000;
    rd_addr        = '0;
    crc_m          = 16'hFFFF;
    repeat (3) @(posedge serial_clock);
    #2;
    resetn = 1'b1;
    check_reset_values("reset");

    // single word, MSB first
    send_word(13'h1803, 0, 1'b0, 0);
    idle(2);

    // full frame of identical words
    clear_frame();
    for (int k = 0; k < NP; k++) send_word(13'h0403, k, (k == NP - 1), 0);
    check("frame_done_level", 32'(frame_done), 32'h1);
    check("frame_crc",        32'(crc_out),    32'(crc_m));
    expected_crc = crc_m;
    idle(1);
    check("crc_match_hit",  32'(crc_match), 32'h1);
    expected_crc = crc_m ^ 16'h0001;
    idle(1);
    check("crc_match_miss", 32'(crc_match), 32'h0);

    // overrun after frame_done, then restart
    crc_saved = crc_out;
    send_bit(1'b1);
    idle(2);
    check("overrun_set",        32'(overrun),    32'h1);
    check("overrun_crc_frozen", 32'(crc_out),    32'(crc_saved));
    check("overrun_frame_done", 32'(frame_done), 32'h1);
    clear_frame();
    check("clr_overrun",    32'(overrun),    32'h0);
    check("clr_frame_done", 32'(frame_done), 32'h0);
    check("clr_crc",        32'(crc_out),    32'hFFFF);
    check("clr_crc_match",  32'(crc_match),  32'h0);

    // stall for 5 cycles after bit 6
    send_word(13'h15A7, 0, 1'b0, 6);
    idle(2);
    check("stall_crc", 32'(crc_out), 32'(crc_m));

    // frame_clr colliding with bit 10 of word 3
    clear_frame();
    for (int k = 0; k < 3; k++) send_word(13'h0AAA ^ 13'(k), k, 1'b0, 0);
    for (int i = 0; i < 9; i++) send_bit(i[0]);
    frame_clr      = 1'b1;
    shift_en       = 1'b1;
    serial_data_in = 1'b1;
    @(posedge serial_clock);
    #2;
    frame_clr = 1'b0;
    shift_en  = 1'b0;
    crc_m     = 16'hFFFF;
    check("clrcol_word_out_kept",   32'(word_out),   32'(13'h0AAA ^ 13'd2));
    check("clrcol_word_index_kept", 32'(word_index), 32'd2);
    check("clrcol_crc",             32'(crc_out),    32'hFFFF);
    idle(1);
    send_word(13'h1F0F, 0, 1'b0, 0);
    idle(1);
    check("clrcol_next_crc", 32'(crc_out), 32'(crc_m));

    // asynchronous reset right after word 8 completes
    clear_frame();
    for (int k = 0; k < 9; k++) send_word(13'h0100 + 13'(k), k, 1'b0, 0);
    check("pre_reset_word_valid", 32'(word_valid), 32'h1);
    sb_q.delete();
    resetn = 1'b0;
    #1;
    check_reset_values("async_reset");
    @(posedge serial_clock);
    #2;
    resetn = 1'b1;
    crc_m  = 16'hFFFF;

    // distinct-word frame for capture readback
    for (int k = 0; k < NP; k++) begin
      logic [PB-1:0] w;
      w = 13'h00A5 + 13'(k) * 13'h0101;
      if (k == 4) cap_w4 = w;
      send_word(w, k, (k == NP - 1), 0);
    end
    expected_crc = crc_m;
    idle(1);
    check("cap_frame_crc_match", 32'(crc_match), 32'h1);
    rd_addr = IW'(4);
    #1;
`ifdef GPIO_MON_CAPTURE_EN
    check("rd_addr_4", 32'(rd_data), 32'(cap_w4));
`else
    check("rd_addr_4", 32'(rd_data), 32'h0);
`endif
    rd_addr = IW'(25);
    #1;
    check("rd_addr_25", 32'(rd_data), 32'h0);

    begin
      int guard;
      guard = 0;
      while (sb_q.size() != 0 && guard < 20) begin
        @(posedge serial_clock);
        guard++;
      end
      check("scoreboard_drained", 32'(sb_q.size()), 32'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
